// File: rtl/sva_result_collector.sv
// Collects checker success/failure/lazy-success events into saturating counters and a timestamped
// event FIFO. Optional first-failure capture is enabled by defining SVA_RESULT_FIRST_FAIL_EN.
module sva_result_collector #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 gclk_posedge_flag,
  input  logic                 succ,
  input  logic                 fail,
  input  logic                 lazy_succ,
  input  logic                 clr,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [1:0]           ev_kind,
  output logic [TS_WIDTH-1:0]  ev_ts,
  output logic [CNT_WIDTH-1:0] succ_cnt,
  output logic [CNT_WIDTH-1:0] fail_cnt,
  output logic [CNT_WIDTH-1:0] lazy_cnt,
  output logic                 overflow,
  output logic                 first_fail_vld,
  output logic [TS_WIDTH-1:0]  first_fail_ts
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FillW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StErr  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CNT_WIDTH-1:0] succ_cnt_q, succ_cnt_d;
  logic [CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_WIDTH-1:0] lazy_cnt_q, lazy_cnt_d;
  logic                 overflow_q, overflow_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0]     fill_q, fill_d;

  logic [1:0]           kind_mem_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]  ts_mem_q   [FIFO_DEPTH];

  logic                 active;
  logic                 fifo_full;
  logic                 any_ev;
  logic                 push_req;
  logic                 push;
  logic                 pop;
  logic                 ovf_evt;
  logic [1:0]           push_kind;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic                 en);
    return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  assign active    = (state_q != StIdle);
  assign ev_valid  = (fill_q != '0);
  assign fifo_full = (fill_q == FillW'(FIFO_DEPTH));
  assign any_ev    = succ | fail | lazy_succ;

  // clr suppresses every same-cycle FIFO operation.
  assign pop       = ev_valid && ev_ready && !clr;
  assign push_req  = (state_q == StRun) && any_ev && !clr;
  assign push      = push_req && (!fifo_full || pop);
  assign ovf_evt   = push_req && fifo_full && !pop;
  assign push_kind = fail ? 2'b10 : (succ ? 2'b01 : 2'b11);

  assign ev_kind   = ev_valid ? kind_mem_q[rd_ptr_q] : 2'b00;
  assign ev_ts     = ev_valid ? ts_mem_q[rd_ptr_q] : '0;
  assign succ_cnt  = succ_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign lazy_cnt  = lazy_cnt_q;
  assign overflow  = overflow_q;

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    succ_cnt_d = succ_cnt_q;
    fail_cnt_d = fail_cnt_q;
    lazy_cnt_d = lazy_cnt_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;

    unique case (state_q)
      StIdle: if (gclk_posedge_flag) state_d = StRun;
      StRun:  if (ovf_evt) state_d = StErr;
      StErr:  state_d = StErr;
      default: state_d = StIdle;
    endcase

    // The IDLE->RUN edge itself does not advance the timestamp.
    if (active && gclk_posedge_flag) ts_d = ts_q + TS_WIDTH'(1);

    if (active) begin
      succ_cnt_d = sat_inc(succ_cnt_q, succ);
      fail_cnt_d = sat_inc(fail_cnt_q, fail);
      lazy_cnt_d = sat_inc(lazy_cnt_q, lazy_succ);
    end

    if (ovf_evt) overflow_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + FillW'(1);
      2'b01:   fill_d = fill_q - FillW'(1);
      default: fill_d = fill_q;
    endcase

    if (clr) begin
      state_d    = StIdle;
      ts_d       = '0;
      succ_cnt_d = '0;
      fail_cnt_d = '0;
      lazy_cnt_d = '0;
      overflow_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      ts_q       <= '0;
      succ_cnt_q <= '0;
      fail_cnt_q <= '0;
      lazy_cnt_q <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      succ_cnt_q <= succ_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      lazy_cnt_q <= lazy_cnt_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
    end
  end

  // Storage needs no reset: outputs are masked by ev_valid.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      kind_mem_q[wr_ptr_q] <= push_kind;
      ts_mem_q[wr_ptr_q]   <= ts_q;
    end
  end

`ifdef SVA_RESULT_FIRST_FAIL_EN
  logic                ff_vld_q, ff_vld_d;
  logic [TS_WIDTH-1:0] ff_ts_q, ff_ts_d;

  always_comb begin
    ff_vld_d = ff_vld_q;
    ff_ts_d  = ff_ts_q;
    if (clr) begin
      ff_vld_d = 1'b0;
      ff_ts_d  = '0;
    end else if (active && fail && !ff_vld_q) begin
      ff_vld_d = 1'b1;
      ff_ts_d  = ts_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ff_vld_q <= 1'b0;
      ff_ts_q  <= '0;
    end else begin
      ff_vld_q <= ff_vld_d;
      ff_ts_q  <= ff_ts_d;
    end
  end

  assign first_fail_vld = ff_vld_q;
  assign first_fail_ts  = ff_ts_q;
`else
  assign first_fail_vld = 1'b0;
  assign first_fail_ts  = '0;
`endif

endmodule

// File: tb/tb_sva_result_collector.sv
// Directed bench for sva_result_collector: stimulus pushes expected FIFO entries into a queue and
// a negedge monitor pops and compares them whenever the DUT hands over an entry.
module tb_sva_result_collector;

  localparam int unsigned CW = 4;
  localparam int unsigned TW = 16;
  localparam int unsigned FD = 4;
`ifdef SVA_RESULT_FIRST_FAIL_EN
  localparam bit FfEn = 1'b1;
`else
  localparam bit FfEn = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]    kind;
    logic [TW-1:0] ts;
  } ev_t;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          gclk_posedge_flag, succ, fail, lazy_succ, clr, ev_ready;
  logic          ev_valid;
  logic [1:0]    ev_kind;
  logic [TW-1:0] ev_ts;
  logic [CW-1:0] succ_cnt, fail_cnt, lazy_cnt;
  logic          overflow, first_fail_vld;
  logic [TW-1:0] first_fail_ts;

  int  n_cmp  = 0;
  int  n_fail = 0;
  ev_t exp_q[$];

  sva_result_collector #(
    .CNT_WIDTH (CW),
    .TS_WIDTH  (TW),
    .FIFO_DEPTH(FD)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .gclk_posedge_flag(gclk_posedge_flag),
    .succ             (succ),
    .fail             (fail),
    .lazy_succ        (lazy_succ),
    .clr              (clr),
    .ev_valid         (ev_valid),
    .ev_ready         (ev_ready),
    .ev_kind          (ev_kind),
    .ev_ts            (ev_ts),
    .succ_cnt         (succ_cnt),
    .fail_cnt         (fail_cnt),
    .lazy_cnt         (lazy_cnt),
    .overflow         (overflow),
    .first_fail_vld   (first_fail_vld),
    .first_fail_ts    (first_fail_ts)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic gclk_pulse();
    gclk_posedge_flag = 1'b1;
    tick();
    gclk_posedge_flag = 1'b0;
    tick();
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [TW-1:0] ts);
    ev_t e;
    e.kind = kind;
    e.ts   = ts;
    exp_q.push_back(e);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_succ_cnt"}, 32'(succ_cnt), 0);
    check({tag, "_fail_cnt"}, 32'(fail_cnt), 0);
    check({tag, "_lazy_cnt"}, 32'(lazy_cnt), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_ev_valid"}, 32'(ev_valid), 0);
    check({tag, "_ev_kind"}, 32'(ev_kind), 0);
    check({tag, "_ev_ts"}, 32'(ev_ts), 0);
    check({tag, "_ff_vld"}, 32'(first_fail_vld), 0);
    check({tag, "_ff_ts"}, 32'(first_fail_ts), 0);
    check({tag, "_state"}, 32'(dut.state_q), 0);
    check({tag, "_ts"}, 32'(dut.ts_q), 0);
  endtask

  // Scoreboard monitor: an entry is handed over when valid and ready meet at the next edge.
  always @(negedge sys_clk) begin
    ev_t e;
    if (sys_rst_n && ev_valid && ev_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_entry: got kind %b ts %0d, required none", ev_kind, ev_ts);
      end else begin
        e = exp_q.pop_front();
        if ({ev_kind, ev_ts} !== {e.kind, e.ts}) begin
          n_fail++;
          $display("FAIL entry: got kind %b ts %0d, required kind %b ts %0d",
                   ev_kind, ev_ts, e.kind, e.ts);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    {gclk_posedge_flag, succ, fail, lazy_succ, clr, ev_ready} = '0;
    #12;
    check_cleared("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();

    // Events in IDLE are ignored.
    succ = 1'b1;
    fail = 1'b1;
    tick();
    {succ, fail} = '0;
    check("idle_succ_cnt", 32'(succ_cnt), 0);
    check("idle_fail_cnt", 32'(fail_cnt), 0);
    check("idle_ev_valid", 32'(ev_valid), 0);
    check("idle_ff_vld", 32'(first_fail_vld), 0);

    // Three user-clock edges: RUN with timestamp 2, then a success.
    repeat (3) gclk_pulse();
    check("run_state", 32'(dut.state_q), 1);
    succ = 1'b1;
    expect_ev(2'b01, 16'd2);
    check("pre_push_valid", 32'(ev_valid), 0);
    tick();
    succ = 1'b0;
    check("t1_ev_valid", 32'(ev_valid), 1);
    check("t1_ev_kind", 32'(ev_kind), 1);
    check("t1_ev_ts", 32'(ev_ts), 2);
    check("t1_succ_cnt", 32'(succ_cnt), 1);
    ev_ready = 1'b1;
    tick();
    check("t1_drained", 32'(ev_valid), 0);

    // Fail and success together: both count, one fail entry.
    fail = 1'b1;
    succ = 1'b1;
    expect_ev(2'b10, 16'd2);
    tick();
    {fail, succ} = '0;
    check("t2_fail_cnt", 32'(fail_cnt), 1);
    check("t2_succ_cnt", 32'(succ_cnt), 2);
    check("t2_ev_kind", 32'(ev_kind), 2);
    tick();
    check("t2_single_entry", 32'(ev_valid), 0);
    check("t2_ff_vld", 32'(first_fail_vld), 32'(FfEn));
    check("t2_ff_ts", 32'(first_fail_ts), FfEn ? 2 : 0);

    // Fill the FIFO with distinct entries, then push and pop together while full.
    ev_ready = 1'b0;
    gclk_posedge_flag = 1'b1;
    succ = 1'b1;       expect_ev(2'b01, 16'd2); tick();
    succ = 1'b0;
    lazy_succ = 1'b1;  expect_ev(2'b11, 16'd3); tick();
    lazy_succ = 1'b0;
    succ = 1'b1;       expect_ev(2'b01, 16'd4); tick();
    succ = 1'b0;
    lazy_succ = 1'b1;  expect_ev(2'b11, 16'd5); tick();
    {lazy_succ, gclk_posedge_flag} = '0;
    check("full_valid", 32'(ev_valid), 1);
    check("full_overflow", 32'(overflow), 0);
    tick();
    check("hold_kind", 32'(ev_kind), 1);
    check("hold_ts", 32'(ev_ts), 2);
    succ = 1'b1;
    ev_ready = 1'b1;
    expect_ev(2'b01, 16'd6);
    tick();
    succ = 1'b0;
    check("pp_overflow", 32'(overflow), 0);
    check("pp_state", 32'(dut.state_q), 1);
    check("pp_head_kind", 32'(ev_kind), 3);
    check("pp_head_ts", 32'(ev_ts), 3);
    repeat (4) tick();
    check("pp_drained", 32'(ev_valid), 0);
    check("pp_succ_cnt", 32'(succ_cnt), 5);
    check("pp_lazy_cnt", 32'(lazy_cnt), 2);

    // clr wins over a same-cycle event.
    clr = 1'b1;
    succ = 1'b1;
    tick();
    {clr, succ} = '0;
    check_cleared("clr1");

    // Overflow: five successes into a four-entry FIFO with no consumer.
    ev_ready = 1'b0;
    gclk_pulse();
    succ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_ev(2'b01, 16'd0);
      tick();
    end
    succ = 1'b0;
    check("ovf_succ_cnt", 32'(succ_cnt), 5);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_state", 32'(dut.state_q), 2);
    check("ovf_valid", 32'(ev_valid), 1);
    fail = 1'b1;
    tick();
    fail = 1'b0;
    check("err_fail_cnt", 32'(fail_cnt), 1);
    lazy_succ = 1'b1;
    repeat (20) tick();
    lazy_succ = 1'b0;
    check("sat_lazy_cnt", 32'(lazy_cnt), 15);
    ev_ready = 1'b1;
    repeat (4) tick();
    check("err_drained", 32'(ev_valid), 0);
    succ = 1'b1;
    tick();
    succ = 1'b0;
    tick();
    check("err_no_push", 32'(ev_valid), 0);
    check("err_succ_cnt", 32'(succ_cnt), 6);
    check("err_sticky", 32'(overflow), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_cleared("clr2");

    // First-failure capture: fails at timestamps 7 and 9.
    repeat (8) gclk_pulse();
    fail = 1'b1;
    expect_ev(2'b10, 16'd7);
    tick();
    fail = 1'b0;
    repeat (2) gclk_pulse();
    fail = 1'b1;
    expect_ev(2'b10, 16'd9);
    tick();
    fail = 1'b0;
    tick();
    check("ff_fail_cnt", 32'(fail_cnt), 2);
    check("ff_vld", 32'(first_fail_vld), 32'(FfEn));
    check("ff_ts", 32'(first_fail_ts), FfEn ? 7 : 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_cleared("clr3");

    // Asynchronous reset mid-transfer discards the FIFO.
    ev_ready = 1'b0;
    gclk_pulse();
    succ = 1'b1;
    expect_ev(2'b01, 16'd0);
    tick();
    succ = 1'b0;
    check("rst_pre_valid", 32'(ev_valid), 1);
    ev_ready = 1'b1;
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(ev_valid), 0);
    check("rst_async_cnt", 32'(succ_cnt), 0);
    check("rst_async_state", 32'(dut.state_q), 0);
    exp_q.delete();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    check("rst_post_valid", 32'(ev_valid), 0);

    check("leftover_entries", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
